// File: rtl/ifq_pkg.sv
// ----------------------------------------------------------------------------
// ifq_pkg
// Shared types and constants for the IF/ID instruction queue.
//   ifq_entry_t        : one queue entry {pc, npc, ir}
//   IFQ_DEPTH_DEFAULT  : default number of queue entries
//   ifq_entry_zero     : all-zero entry, driven on the outputs when empty
// ----------------------------------------------------------------------------
package ifq_pkg;

    localparam int IFQ_DEPTH_DEFAULT = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] npc;
        logic [31:0] ir;
    } ifq_entry_t;

    function automatic ifq_entry_t ifq_entry_zero();
        ifq_entry_t e;
        e.pc  = 32'h0000_0000;
        e.npc = 32'h0000_0000;
        e.ir  = 32'h0000_0000;
        return e;
    endfunction

endpackage

// File: rtl/ifq_ptr.sv
// ----------------------------------------------------------------------------
// ifq_ptr
// Wrapping pointer of AW bits; wraps naturally modulo 2**AW.
// Ports:
//   clk  : clock
//   rst  : asynchronous active-low reset (pointer -> 0)
//   inc  : advance the pointer by one
//   clr  : return the pointer to 0 (wins over inc)
//   ptr  : current pointer value
// ----------------------------------------------------------------------------
module ifq_ptr #(
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          clr,
    output logic [AW-1:0] ptr
);

    logic [AW-1:0] ptr_r;

    // Pointer register: clear has priority over increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_r <= '0;
        end else if (clr) begin
            ptr_r <= '0;
        end else if (inc) begin
            ptr_r <= ptr_r + AW'(1);
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign ptr = ptr_r;

endmodule

// File: rtl/if_id_queue.sv
// ----------------------------------------------------------------------------
// if_id_queue
// In-order instruction queue decoupling fetch from decode. Holds up to DEPTH
// {PC, NPC, IR} entries and presents the oldest one to decode. ifq_full_out is
// the fetch stall; ex_take_branch_in flushes everything.
// Optional feature macro: IFQ_BYPASS_EN -- when the queue is empty, a fetched
// instruction is forwarded combinationally to decode (0-cycle latency) and is
// not stored at all if decode accepts it in the same cycle.
// Ports:
//   clk, rst (async active-low)
//   if_PC_in/if_NPC_in/if_IR_in/if_valid_inst_in : push side from fetch
//   ex_take_branch_in : flush
//   id_ready_in       : decode accepts the head entry
//   if_id_*_out       : head entry (zero when empty)
//   ifq_full_out      : queue full
//   ifq_count_out     : occupancy
// ----------------------------------------------------------------------------
module if_id_queue
    import ifq_pkg::*;
#(
    parameter int DEPTH = IFQ_DEPTH_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [31:0]                if_PC_in,
    input  logic [31:0]                if_NPC_in,
    input  logic [31:0]                if_IR_in,
    input  logic                       if_valid_inst_in,
    input  logic                       ex_take_branch_in,
    input  logic                       id_ready_in,
    output logic [31:0]                if_id_PC_out,
    output logic [31:0]                if_id_NPC_out,
    output logic [31:0]                if_id_IR_out,
    output logic                       if_id_valid_inst_out,
    output logic                       ifq_full_out,
    output logic [$clog2(DEPTH):0]     ifq_count_out
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    ifq_entry_t        mem_r [DEPTH];
    logic [CW-1:0]     count_r;
    logic [AW-1:0]     head_s;
    logic [AW-1:0]     tail_s;
    logic              empty_s;
    logic              full_s;
    logic              valid_out_s;
    logic              pop_s;
    logic              push_s;
    logic              pop_q_s;
    logic              push_q_s;
    logic              bypass_s;
    ifq_entry_t        in_entry_s;
    ifq_entry_t        out_entry_s;

    assign empty_s  = (count_r == {CW{1'b0}});
    assign full_s   = (count_r == FULL_CNT);
    assign in_entry_s.pc  = if_PC_in;
    assign in_entry_s.npc = if_NPC_in;
    assign in_entry_s.ir  = if_IR_in;

`ifdef IFQ_BYPASS_EN
    // rst gates the bypass so every output reads 0 while reset is held.
    assign bypass_s = rst & empty_s & if_valid_inst_in & ~ex_take_branch_in;
`else
    assign bypass_s = 1'b0;
`endif

    // Handshake decode; a bypassed instruction accepted by decode never
    // touches the array, so the queue-side pop/push are masked for it.
    always_comb begin
        valid_out_s = ~empty_s | bypass_s;
        pop_s       = id_ready_in & valid_out_s;
        push_s      = if_valid_inst_in & (~full_s | pop_s);
        if (bypass_s) begin
            pop_q_s  = 1'b0;
            push_q_s = push_s & ~pop_s;
        end else begin
            pop_q_s  = pop_s;
            push_q_s = push_s;
        end
    end

    ifq_ptr #(.AW(AW)) u_head (
        .clk (clk),
        .rst (rst),
        .inc (pop_q_s),
        .clr (ex_take_branch_in),
        .ptr (head_s)
    );

    ifq_ptr #(.AW(AW)) u_tail (
        .clk (clk),
        .rst (rst),
        .inc (push_q_s),
        .clr (ex_take_branch_in),
        .ptr (tail_s)
    );

    // Occupancy counter: flush first, then +1/-1/hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r <= '0;
        end else if (ex_take_branch_in) begin
            count_r <= '0;
        end else if (push_q_s && !pop_q_s) begin
            count_r <= count_r + CW'(1);
        end else if (pop_q_s && !push_q_s) begin
            count_r <= count_r - CW'(1);
        end else begin
            count_r <= count_r;
        end
    end

    // Entry storage; contents are not reset since they are hidden while empty.
    always_ff @(posedge clk) begin
        if (push_q_s && !ex_take_branch_in) begin
            mem_r[tail_s] <= in_entry_s;
        end
    end

    // Output mux: bypass, head entry, or zeros when empty.
    always_comb begin
        out_entry_s = ifq_entry_zero();
        if (bypass_s) begin
            out_entry_s = in_entry_s;
        end else if (!empty_s) begin
            out_entry_s = mem_r[head_s];
        end else begin
            out_entry_s = ifq_entry_zero();
        end
    end

    assign if_id_PC_out         = out_entry_s.pc;
    assign if_id_NPC_out        = out_entry_s.npc;
    assign if_id_IR_out         = out_entry_s.ir;
    assign if_id_valid_inst_out = valid_out_s;
    assign ifq_full_out         = full_s;
    assign ifq_count_out        = count_r;

endmodule

// File: tb/tb_if_id_queue.sv
module tb_if_id_queue;

    logic        clk;
    logic        rst;
    logic [31:0] if_PC_in;
    logic [31:0] if_NPC_in;
    logic [31:0] if_IR_in;
    logic        if_valid_inst_in;
    logic        ex_take_branch_in;
    logic        id_ready_in;
    logic [31:0] if_id_PC_out;
    logic [31:0] if_id_NPC_out;
    logic [31:0] if_id_IR_out;
    logic        if_id_valid_inst_out;
    logic        ifq_full_out;
    logic [2:0]  ifq_count_out;

    int checks;
    int errors;

    if_id_queue #(.DEPTH(4)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .if_PC_in             (if_PC_in),
        .if_NPC_in            (if_NPC_in),
        .if_IR_in             (if_IR_in),
        .if_valid_inst_in     (if_valid_inst_in),
        .ex_take_branch_in    (ex_take_branch_in),
        .id_ready_in          (id_ready_in),
        .if_id_PC_out         (if_id_PC_out),
        .if_id_NPC_out        (if_id_NPC_out),
        .if_id_IR_out         (if_id_IR_out),
        .if_id_valid_inst_out (if_id_valid_inst_out),
        .ifq_full_out         (ifq_full_out),
        .ifq_count_out        (ifq_count_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        push;
        logic [31:0] pc;
        logic        flush;
        logic        ready;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [2:0]  exp_count;
        logic        exp_full;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] ir_of(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Full head-state comparison; NPC/IR derive from PC unless the queue is empty.
    task automatic chk_state(input string tag, input logic v, input logic [31:0] pc,
                             input logic [2:0] cnt, input logic f);
        chk({tag, " valid"}, {31'd0, if_id_valid_inst_out}, {31'd0, v});
        chk({tag, " pc"},    if_id_PC_out, pc);
        chk({tag, " npc"},   if_id_NPC_out, v ? pc + 32'd4 : 32'd0);
        chk({tag, " ir"},    if_id_IR_out,  v ? ir_of(pc) : 32'd0);
        chk({tag, " count"}, {29'd0, ifq_count_out}, {29'd0, cnt});
        chk({tag, " full"},  {31'd0, ifq_full_out}, {31'd0, f});
    endtask

    task automatic drive(input logic push, input logic [31:0] pc, input logic flush, input logic ready);
        if_valid_inst_in  = push;
        if_PC_in          = push ? pc : 32'hDEAD_BEEF;
        if_NPC_in         = pc + 32'd4;
        if_IR_in          = ir_of(pc);
        ex_take_branch_in = flush;
        id_ready_in       = ready;
    endtask

    task automatic idle();
        drive(1'b0, 32'd0, 1'b0, 1'b0);
    endtask

    // One cycle: drive at negedge, let the edge happen, go idle, then sample.
    task automatic step(input logic push, input logic [31:0] pc, input logic flush, input logic ready);
        @(negedge clk);
        drive(push, pc, flush, ready);
        @(posedge clk);
        #1;
        idle();
        #1;
    endtask

    function automatic vec_t mk(input logic push, input logic [31:0] pc, input logic flush,
                                input logic ready, input logic ev, input logic [31:0] epc,
                                input logic [2:0] ec, input logic ef);
        vec_t v;
        v.push = push; v.pc = pc; v.flush = flush; v.ready = ready;
        v.exp_valid = ev; v.exp_pc = epc; v.exp_count = ec; v.exp_full = ef;
        return v;
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        idle();

        // push, pc, flush, ready | valid, head pc, count, full
        vecs.push_back(mk(1, 32'h00, 0, 0, 1, 32'h00, 3'd1, 0));
        vecs.push_back(mk(1, 32'h04, 0, 0, 1, 32'h00, 3'd2, 0));
        vecs.push_back(mk(1, 32'h08, 0, 0, 1, 32'h00, 3'd3, 0));
        vecs.push_back(mk(1, 32'h0C, 0, 0, 1, 32'h00, 3'd4, 1));
        vecs.push_back(mk(1, 32'h10, 0, 0, 1, 32'h00, 3'd4, 1)); // dropped
        vecs.push_back(mk(0, 32'h00, 0, 1, 1, 32'h04, 3'd3, 0));
        vecs.push_back(mk(0, 32'h00, 0, 1, 1, 32'h08, 3'd2, 0));
        vecs.push_back(mk(0, 32'h00, 0, 1, 1, 32'h0C, 3'd1, 0));
        vecs.push_back(mk(0, 32'h00, 0, 1, 0, 32'h00, 3'd0, 0));
        vecs.push_back(mk(1, 32'h20, 0, 0, 1, 32'h20, 3'd1, 0));
        vecs.push_back(mk(1, 32'h24, 0, 0, 1, 32'h20, 3'd2, 0));
        vecs.push_back(mk(1, 32'h28, 0, 0, 1, 32'h20, 3'd3, 0));
        vecs.push_back(mk(1, 32'h2C, 0, 0, 1, 32'h20, 3'd4, 1));
        vecs.push_back(mk(1, 32'h30, 0, 1, 1, 32'h24, 3'd4, 1)); // push+pop while full
        vecs.push_back(mk(0, 32'h00, 0, 1, 1, 32'h28, 3'd3, 0));
        vecs.push_back(mk(0, 32'h00, 0, 1, 1, 32'h2C, 3'd2, 0));
        vecs.push_back(mk(0, 32'h00, 0, 1, 1, 32'h30, 3'd1, 0)); // wrapped entry
        vecs.push_back(mk(1, 32'h34, 0, 0, 1, 32'h30, 3'd2, 0));
        vecs.push_back(mk(1, 32'h38, 0, 0, 1, 32'h30, 3'd3, 0));
        vecs.push_back(mk(1, 32'h40, 1, 0, 0, 32'h00, 3'd0, 0)); // flush beats push
        vecs.push_back(mk(1, 32'h80, 0, 0, 1, 32'h80, 3'd1, 0));
        vecs.push_back(mk(1, 32'h84, 0, 0, 1, 32'h80, 3'd2, 0));

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_state("reset", 1'b0, 32'd0, 3'd0, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].push, vecs[i].pc, vecs[i].flush, vecs[i].ready);
            chk_state($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_pc,
                      vecs[i].exp_count, vecs[i].exp_full);
        end

        // Asynchronous reset mid-cycle with count 2: outputs clear before any edge.
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk_state("async_rst", 1'b0, 32'd0, 3'd0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        step(1'b1, 32'h00, 1'b0, 1'b0);
        chk_state("post_rst_push", 1'b1, 32'h00, 3'd1, 1'b0);
        step(1'b0, 32'h00, 1'b0, 1'b1);
        chk_state("post_rst_pop", 1'b0, 32'h00, 3'd0, 1'b0);

        // Empty queue, push 0x10 with decode ready.
        @(negedge clk);
        drive(1'b1, 32'h10, 1'b0, 1'b1);
        #1;
`ifdef IFQ_BYPASS_EN
        chk("bypass same-cycle valid", {31'd0, if_id_valid_inst_out}, 32'd1);
        chk("bypass same-cycle pc", if_id_PC_out, 32'h10);
`else
        chk("nobypass same-cycle valid", {31'd0, if_id_valid_inst_out}, 32'd0);
        chk("nobypass same-cycle pc", if_id_PC_out, 32'h0);
`endif
        @(posedge clk);
        #1;
        idle();
        #1;
`ifdef IFQ_BYPASS_EN
        chk_state("bypass after", 1'b0, 32'h00, 3'd0, 1'b0);
`else
        chk_state("nobypass after", 1'b1, 32'h10, 3'd1, 1'b0);
        step(1'b0, 32'h00, 1'b0, 1'b1);
        chk_state("nobypass drain", 1'b0, 32'h00, 3'd0, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_id_queue.md
# if_id_queue

Decoupling instruction queue between the fetch stage and the decode stage. Each cycle it accepts one fetched instruction with its PC, PC+4 and valid flag, holds up to DEPTH entries in order, and presents the oldest entry to decode. When full it raises back-pressure that the fetch stage uses as its stall (`hazard_flag`). A taken branch from EX flushes all entries.

## Interface
Parameters:
- DEPTH, 4: number of entries; a power of two, at least 2.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- if_PC_in  in  32  PC of the fetched instruction.
- if_NPC_in  in  32  PC+4 of the fetched instruction.
- if_IR_in  in  32  fetched instruction word.
- if_valid_inst_in  in  1  push request; the other fetch inputs are meaningful only when this is 1.
- ex_take_branch_in  in  1  flush request from EX.
- id_ready_in  in  1  decode accepts the head entry this cycle.
- if_id_PC_out  out  32  PC of the head entry.
- if_id_NPC_out  out  32  PC+4 of the head entry.
- if_id_IR_out  out  32  instruction word of the head entry.
- if_id_valid_inst_out  out  1  head entry is valid.
- ifq_full_out  out  1  queue full; drives the fetch stall.
- ifq_count_out  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- State: DEPTH-entry array of {PC, NPC, IR}; head and tail pointers of width $clog2(DEPTH), which wrap naturally modulo DEPTH; occupancy count of width $clog2(DEPTH)+1.
- push = if_valid_inst_in & (~ifq_full_out | pop).
- pop = id_ready_in & if_id_valid_inst_out.
- Push writes the array at tail, then tail increments. Pop increments head. Count changes by +1 on push only, by -1 on pop only, and is unchanged when both occur.
- Push while full without a pop: the push is dropped. The fetch stage must already be stalled by ifq_full_out, so this is an error case and has no side effects.
- Flush has priority over everything else. It sets head, tail and count to 0 and discards any push or pop in the same cycle.
- Outputs are combinational from the head entry and the registered count:
  - if_id_valid_inst_out = (count != 0).
  - ifq_full_out = (count == DEPTH).
  - When the queue is empty, the PC, NPC and IR outputs are 0.
- Full and empty are decided by count, not by pointer equality.

## Timing
- Reset, asynchronous, while rst = 0: pointers and count are 0, and every output is 0. The array contents are not reset and are never visible while count is 0. Reset asserted in the middle of operation takes effect immediately, independent of the clock.
- Push-to-visible latency is 1 cycle: an instruction pushed at edge N appears on if_id_* after edge N if it is the head.
- ifq_full_out asserts in the cycle after the push that fills the queue. It deasserts in the cycle after the first pop.
- When full, a simultaneous push and pop is accepted and the queue stays full.
- Flush at edge N: the queue is empty and ifq_full_out = 0 after edge N. The first instruction from the branch target can be pushed at edge N+1.
- Wrap-around: after DEPTH pushes, tail returns to 0 with no bubble.

## Configuration
- IFQ_BYPASS_EN defined:
  - When count == 0 and if_valid_inst_in = 1 with no flush, the fetch inputs drive if_id_* combinationally, and if_id_valid_inst_out = 1 in the same cycle.
  - If id_ready_in is also 1, the instruction is consumed without being written, and count stays 0.
  - Push-to-visible latency becomes 0.
- IFQ_BYPASS_EN undefined: behaviour is exactly as described in Operation and Timing (1-cycle latency).

## Structure
- Shared package `ifq_pkg`:
  - typedef `ifq_entry_t` (packed struct of pc, npc and ir, each 32 bits).
  - constant `IFQ_DEPTH_DEFAULT = 4`.
- Sub-module `ifq_ptr`: a wrapping pointer of width $clog2(DEPTH) with increment and clear inputs. It is instantiated once for head and once for tail.
- Array, count and output muxing are written inline.

## Test plan
- Reset, then push PCs 0x0, 0x4 and 0x8 with id_ready_in = 0 -> count 3, head PC 0x0, IR equals the first pushed word, full = 0.
- Push 4 entries with id_ready_in = 0 -> full = 1 after the 4th edge. A 5th push is dropped, and after popping, the head sequence is 0x0, 0x4, 0x8, 0xC.
- Full queue, push and pop in the same cycle -> count stays 4, full stays 1, and the new entry appears after 3 further pops. This covers pointer wrap.
- Count 3, flush asserted together with a push of 0x40 -> count 0, valid 0, and 0x40 is discarded. A push of 0x80 on the next cycle becomes the head.
- Assert rst = 0 asynchronously mid-cycle with count 2 -> all outputs are 0 before the next clock edge. After release, the first push is at PC 0x0.
- IFQ_BYPASS_EN: empty queue, push 0x10 with id_ready_in = 1 -> if_id_PC_out = 0x10 and valid = 1 in the same cycle, and count stays 0. Without the macro -> it is visible one cycle later.
